mmu_translate: RTL and testbench

- Address-translation stage that sits directly upstream of the CPU's single-port program/data RAM.
- Takes a logical (per-process) address and walks the per-process segment chain, then returns the physical RAM address or a fault.
- Owns the chain and logical-page tables, which the task switcher programs through a config write port.
- Replaces the inline chain search in the CPU fetch state machine with a stand-alone, handshaked block.

---
 rtl/mmu_translate.sv | 155 +++++++++++++++
 tb/tb_mmu_translate.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mmu_translate.sv
// mmu_translate: logical-to-physical address translation by walking a per-process segment chain.
//
// Ports:
//   clk                clock, rising edge
//   reset              asynchronous active-high reset
//   mmu_enable         0 = identity translation, 1 = chain walk (sampled at accept)
//   start_segment      first physical segment of the process (sampled at accept)
//   req_valid/ready    request handshake; req_logical_addr is the logical address
//   rsp_valid/ready    response handshake; rsp_physical_addr and rsp_fault are the result
//   cfg_we             table write strobe for entry cfg_segment
//   cfg_next           next segment (self-pointer ends the chain)
//   cfg_logical        logical page held by the entry
//   cfg_valid          entry valid bit
//   cfg_busy           high when a table write this cycle would be dropped
module mmu_translate #(
    parameter int PAGE_SIZE    = 70,
    parameter int ADDR_W       = 16,
    parameter int SEG_W        = 10,
    parameter int NUM_SEGMENTS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mmu_enable,
    input  logic [SEG_W-1:0]  start_segment,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_logical_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_physical_addr,
    output logic              rsp_fault,
    input  logic              cfg_we,
    input  logic [SEG_W-1:0]  cfg_segment,
    input  logic [SEG_W-1:0]  cfg_next,
    input  logic [SEG_W-1:0]  cfg_logical,
    input  logic              cfg_valid,
    output logic              cfg_busy
);
    localparam int STEP_W = $clog2(NUM_SEGMENTS) + 1;

    typedef enum logic [1:0] {IDLE, CHECK, WALK, DONE} state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [SEG_W-1:0]    r_start;
    logic                r_en;
    logic [SEG_W-1:0]    r_pos;
    logic [STEP_W-1:0]   r_steps;
    logic                r_req_ready;
    logic                r_rsp_valid;
    logic                r_rsp_fault;
    logic [ADDR_W-1:0]   r_rsp_addr;

    logic [SEG_W-1:0]        r_chain   [NUM_SEGMENTS];
    logic [SEG_W-1:0]        r_logical [NUM_SEGMENTS];
    logic [NUM_SEGMENTS-1:0] r_valid;

    logic [ADDR_W-1:0] w_page;
    logic [ADDR_W-1:0] w_off;
    logic [SEG_W-1:0]  w_seg;
    logic [ADDR_W-1:0] w_phys;
    logic              w_hit;
    logic              w_end;
    logic              w_cfg_wr;

    assign req_ready         = r_req_ready;
    assign rsp_valid         = r_rsp_valid;
    assign rsp_fault         = r_rsp_fault;
    assign rsp_physical_addr = r_rsp_addr;
    assign cfg_busy          = !(r_state == IDLE && !req_valid);
    assign w_cfg_wr          = cfg_we && !cfg_busy;

    // One shared multiplier: CHECK maps page 0 to the start segment, WALK maps to the current position.
    always_comb begin
        w_page = r_addr / ADDR_W'(PAGE_SIZE);
        w_off  = r_addr % ADDR_W'(PAGE_SIZE);
        w_seg  = (r_state == CHECK) ? r_start : r_pos;
        w_phys = ADDR_W'(ADDR_W'(w_seg) * ADDR_W'(PAGE_SIZE) + w_off);
        w_hit  = r_valid[r_pos] && (ADDR_W'(r_logical[r_pos]) == w_page);
        w_end  = (r_chain[r_pos] == r_pos) || (r_steps == STEP_W'(NUM_SEGMENTS));
    end

    always_ff @(posedge clk) begin
        if (w_cfg_wr) begin
            r_chain[cfg_segment]   <= cfg_next;
            r_logical[cfg_segment] <= cfg_logical;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_valid <= '0;
        else if (w_cfg_wr)
            r_valid[cfg_segment] <= cfg_valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_start     <= '0;
            r_en        <= 1'b0;
            r_pos       <= '0;
            r_steps     <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_fault <= 1'b0;
            r_rsp_addr  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_addr      <= req_logical_addr;
                        r_start     <= start_segment;
                        r_en        <= mmu_enable;
                        r_req_ready <= 1'b0;
                        r_state     <= CHECK;
                    end
                end
                CHECK: begin
                    if (!r_en || w_page == '0) begin
                        r_rsp_addr  <= r_en ? w_phys : r_addr;
                        r_rsp_fault <= 1'b0;
                        r_state     <= DONE;
                    end else begin
                        r_pos   <= r_chain[r_start];
                        r_steps <= STEP_W'(1);
                        r_state <= WALK;
                    end
                end
                WALK: begin
                    if (w_hit || w_end) begin
                        r_rsp_addr  <= w_hit ? w_phys : '0;
                        r_rsp_fault <= !w_hit;
                        r_state     <= DONE;
                    end else begin
                        r_pos   <= r_chain[r_pos];
                        r_steps <= r_steps + STEP_W'(1);
                    end
                end
                DONE: begin
                    // First DONE cycle publishes the already-registered result; handshake only once visible.
                    if (!r_rsp_valid)
                        r_rsp_valid <= 1'b1;
                    else if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mmu_translate.sv
// tb_mmu_translate: randomized and directed checks of mmu_translate against a table-walk reference model.
module tb_mmu_translate;
    localparam int PS   = 70;
    localparam int NSEG = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mmu_enable = 1'b1;
    logic [9:0]  start_segment = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_logical_addr = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_physical_addr;
    logic        rsp_fault;
    logic        cfg_we = 1'b0;
    logic [9:0]  cfg_segment = '0;
    logic [9:0]  cfg_next = '0;
    logic [9:0]  cfg_logical = '0;
    logic        cfg_valid = 1'b0;
    logic        cfg_busy;

    int n_chk = 0;
    int n_pass = 0;

    int m_chain   [NSEG];
    int m_logical [NSEG];
    bit m_valid   [NSEG];

    mmu_translate dut (
        .clk(clk), .reset(reset), .mmu_enable(mmu_enable), .start_segment(start_segment),
        .req_valid(req_valid), .req_ready(req_ready), .req_logical_addr(req_logical_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_physical_addr(rsp_physical_addr),
        .rsp_fault(rsp_fault), .cfg_we(cfg_we), .cfg_segment(cfg_segment), .cfg_next(cfg_next),
        .cfg_logical(cfg_logical), .cfg_valid(cfg_valid), .cfg_busy(cfg_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Expected result of one request; latency counted in edges after the accept edge.
    function automatic void model(input int addr, input int start, input bit en,
                                  output int phys, output bit flt, output int lat);
        int page, off, pos;
        flt  = 1'b0;
        lat  = 2;
        phys = addr;
        if (!en) return;
        page = addr / PS;
        off  = addr % PS;
        if (page == 0) begin
            phys = (start * PS + off) % 65536;
            return;
        end
        pos = m_chain[start];
        for (int k = 1; k <= NSEG; k++) begin
            lat = 2 + k;
            if (m_valid[pos] && m_logical[pos] == page) begin
                phys = (pos * PS + off) % 65536;
                return;
            end
            if (m_chain[pos] == pos || k == NSEG) begin
                flt  = 1'b1;
                phys = 0;
                return;
            end
            pos = m_chain[pos];
        end
    endfunction

    task automatic cfg_wr(input int seg, input int nxt, input int lg, input bit v);
        cfg_we = 1'b1; cfg_segment = 10'(seg); cfg_next = 10'(nxt); cfg_logical = 10'(lg); cfg_valid = v;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        m_chain[seg] = nxt; m_logical[seg] = lg; m_valid[seg] = v;
    endtask

    // Issue one request from IDLE; optionally collide a table write with it, and hold off rsp_ready.
    task automatic do_req(input string tag, input int addr, input int start, input bit en,
                          input int hold, input bit clash);
        int ephys, elat, cyc;
        bit eflt;
        model(addr, start, en, ephys, eflt, elat);
        chk({tag, " req_ready"}, 32'(req_ready), 1);
        req_valid = 1'b1; req_logical_addr = 16'(addr); start_segment = 10'(start); mmu_enable = en;
        if (clash) begin
            cfg_we = 1'b1; cfg_segment = 10'd5; cfg_next = 10'd2; cfg_logical = 10'd6; cfg_valid = 1'b1;
            #1;
            chk({tag, " cfg_busy"}, 32'(cfg_busy), 1);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; cfg_we = 1'b0;
        mmu_enable = 1'($urandom); start_segment = 10'($urandom);
        cyc = 0;
        while (!rsp_valid && cyc < NSEG + 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, " latency"}, 32'(cyc), 32'(elat));
        chk({tag, " phys"}, 32'(rsp_physical_addr), 32'(ephys));
        chk({tag, " fault"}, 32'(rsp_fault), 32'(eflt));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, " hold valid"}, 32'(rsp_valid), 1);
            chk({tag, " hold phys"}, 32'(rsp_physical_addr), 32'(ephys));
            chk({tag, " hold req_ready"}, 32'(req_ready), 0);
            chk({tag, " hold cfg_busy"}, 32'(cfg_busy), 1);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, " release valid"}, 32'(rsp_valid), 0);
        chk({tag, " release req_ready"}, 32'(req_ready), 1);
    endtask

    initial begin
        int seg_set [8];
        int hits;
        for (int i = 0; i < NSEG; i++) begin
            m_chain[i] = i; m_logical[i] = 0; m_valid[i] = 1'b0;
        end
        #12;
        chk("reset req_ready", 32'(req_ready), 1);
        chk("reset rsp_valid", 32'(rsp_valid), 0);
        chk("reset rsp_fault", 32'(rsp_fault), 0);
        chk("reset phys", 32'(rsp_physical_addr), 0);
        chk("reset cfg_busy", 32'(cfg_busy), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NSEG; i++) cfg_wr(i, i, 0, 1'b0);

        cfg_wr(0, 5, 0, 1'b1);
        cfg_wr(5, 2, 3, 1'b1);
        cfg_wr(2, 1, 2, 1'b1);
        cfg_wr(1, 1, 1, 1'b1);
        do_req("page0", 45, 0, 1'b1, 0, 1'b0);
        do_req("page3", 215, 0, 1'b1, 0, 1'b0);
        do_req("page2", 140, 0, 1'b1, 0, 1'b0);
        do_req("page1", 71, 0, 1'b1, 0, 1'b0);
        do_req("unmapped", 285, 0, 1'b1, 0, 1'b0);
        do_req("identity", 1000, 0, 1'b0, 10, 1'b0);

        do_req("clash", 425, 0, 1'b1, 0, 1'b1);
        chk("idle cfg_busy", 32'(cfg_busy), 0);
        cfg_wr(5, 2, 6, 1'b1);
        do_req("remap", 425, 0, 1'b1, 0, 1'b0);

        cfg_wr(0, 3, 0, 1'b1);
        cfg_wr(3, 4, 1, 1'b1);
        cfg_wr(4, 3, 2, 1'b1);
        do_req("guard", 7 * PS + 3, 0, 1'b1, 0, 1'b0);

        req_valid = 1'b1; req_logical_addr = 16'(7 * PS + 3); start_segment = 10'd0; mmu_enable = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("midreset req_ready", 32'(req_ready), 1);
        chk("midreset rsp_valid", 32'(rsp_valid), 0);
        #2 reset = 1'b0;
        for (int i = 0; i < NSEG; i++) m_valid[i] = 1'b0;
        hits = 0;
        repeat (NSEG + 20) begin
            @(posedge clk); #1;
            if (rsp_valid) hits++;
        end
        chk("midreset no rsp", 32'(hits), 0);

        for (int i = 0; i < 8; i++) seg_set[i] = $urandom_range(0, NSEG - 1);
        for (int i = 0; i < 8; i++)
            cfg_wr(seg_set[i], seg_set[$urandom_range(0, 7)], $urandom_range(0, 9), ($urandom % 4) != 0);
        for (int i = 0; i < 25; i++) begin
            int a;
            a = ($urandom % 4 == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 10 * PS + PS - 1);
            do_req($sformatf("rand%0d", i), a, seg_set[$urandom_range(0, 7)], ($urandom % 5) != 0,
                   $urandom_range(0, 2), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
